// File: rtl/pulser_pkg.sv
// Shared definitions for the pulser trigger path: config addresses, MODE bits,
// reset defaults and the trigger scheduler state encoding.
package pulser_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;

  localparam int MODE_EXT  = 0;
  localparam int MODE_SKIP = 1;

  localparam int unsigned DEF_PERIOD = 100;
  localparam int unsigned DEF_COUNT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FIRE,
    HOLD,
    WAIT_BUSY
  } sched_state_e;

endpackage

// File: rtl/trigger_scheduler_if.sv
// Command/status bundle between the command decoder, the trigger scheduler
// and the pulser bank.
interface trigger_scheduler_if #(
  parameter int BURST_W = 16
);
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_data;
  logic               start;
  logic               stop;
  logic               ext_trig;
  logic               pulser_busy;
  logic               trig_out;
  logic               running;
  logic [BURST_W-1:0] shot_count;
  logic               overrun;
  logic               done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop, ext_trig, pulser_busy,
    input  trig_out, running, shot_count, overrun, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop, ext_trig, pulser_busy,
    output trig_out, running, shot_count, overrun, done
  );
endinterface

// File: rtl/period_timer.sv
// Loadable down-counter pacing the gap between shots. zero marks the enabled
// tick whose decrement lands on zero, so the FSM can leave HOLD on that edge.
module period_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             zero
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && count != '0) begin
      count <= count - ONE;
    end
  end

  assign zero = en && (count == ONE);
endmodule

// File: rtl/trigger_scheduler.sv
// Pulser trigger scheduler: single shots, finite bursts or continuous trains,
// internally paced or gated by external edges, held back while the bank is busy.
//
// state     | meaning
// IDLE      | no run; waiting for start
// ARM       | waiting for a rising edge of ext_trig
// FIRE      | issue a shot if the pulser bank is free
// HOLD      | period timer running between shots
// WAIT_BUSY | shot pending until pulser_busy drops
module trigger_scheduler
  import pulser_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input logic                clk,
  input logic                rst,
  trigger_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  sched_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cfg_period, act_reload;
  logic [BURST_W-1:0] cfg_count, act_count, shot_q;
  logic [1:0]         cfg_mode;
  logic               act_ext, act_skip;
  logic               ext_q, ext_rise;
  logic               trig_q, running_q, overrun_q, done_q;
  logic               latch, fire, skip_shot, tmr_load, tmr_zero, finished;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_period <= CNT_W'(DEF_PERIOD);
      cfg_count  <= BURST_W'(DEF_COUNT);
      cfg_mode   <= '0;
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        ADDR_PERIOD: cfg_period <= bus.cfg_data[CNT_W-1:0];
        ADDR_COUNT:  cfg_count  <= bus.cfg_data[BURST_W-1:0];
        ADDR_MODE:   cfg_mode   <= bus.cfg_data[1:0];
        default:     ;
      endcase
    end
  end

  // Run parameters are frozen at start; PERIOD below 2 behaves as 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_reload <= CNT_W'(DEF_PERIOD - 1);
      act_count  <= BURST_W'(DEF_COUNT);
      act_ext    <= 1'b0;
      act_skip   <= 1'b0;
    end else if (latch) begin
      act_reload <= (cfg_period < CNT_W'(2)) ? ONE_C : cfg_period - ONE_C;
      act_count  <= cfg_count;
      act_ext    <= cfg_mode[MODE_EXT];
      act_skip   <= cfg_mode[MODE_SKIP];
    end
  end

  period_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (act_reload),
    .en    (state_q == HOLD),
    .zero  (tmr_zero)
  );

  assign ext_rise = bus.ext_trig && !ext_q;
  assign finished = (act_count != '0) && (shot_q == act_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    fire      = 1'b0;
    skip_shot = 1'b0;
    tmr_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && !running_q) begin
          latch   = 1'b1;
          state_d = cfg_mode[MODE_EXT] ? ARM : FIRE;
        end
      end
      ARM: begin
        if (bus.stop)    state_d = IDLE;
        else if (ext_rise) state_d = FIRE;
      end
      FIRE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (!bus.pulser_busy) begin
          fire     = 1'b1;
          tmr_load = 1'b1;
          state_d  = HOLD;
        end else if (act_skip) begin
          skip_shot = 1'b1;
          tmr_load  = 1'b1;
          state_d   = HOLD;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.stop)              state_d = IDLE;
        else if (!bus.pulser_busy) state_d = FIRE;
      end
      HOLD: begin
        if (bus.stop)      state_d = IDLE;
        else if (tmr_zero) state_d = finished ? IDLE : (act_ext ? ARM : FIRE);
      end
      default: state_d = IDLE;
    endcase
  end

  // running trails the FSM by one cycle; done marks its first idle cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q     <= 1'b0;
      trig_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      shot_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      ext_q     <= bus.ext_trig;
      trig_q    <= fire;
      running_q <= (state_q != IDLE);
      done_q    <= running_q && (state_q == IDLE);
      if (latch) begin
        shot_q    <= '0;
        overrun_q <= 1'b0;
      end else begin
        if (fire && shot_q != '1) shot_q <= shot_q + BURST_W'(1);
        if (skip_shot)            overrun_q <= 1'b1;
      end
    end
  end

  assign bus.trig_out   = trig_q;
  assign bus.running    = running_q;
  assign bus.shot_count = shot_q;
  assign bus.overrun    = overrun_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_trigger_scheduler.sv
// Bench for trigger_scheduler: a table of directed runs with hand-computed
// trigger cycles, plus start/stop collision and mid-run reset sequences.
module tb_trigger_scheduler;
  import pulser_pkg::*;

  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trigger_scheduler_if #(.BURST_W(BW)) bus ();

  trigger_scheduler #(.CNT_W(32), .BURST_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int           period;
    int           count;
    int           mode;
    bit           cfg;
    int           busy_from;
    int           busy_to;
    logic [127:0] ext_mask;
    int           stop_at;
    int           wr_at;
    int           wr_val;
    int           ncyc;
    logic [127:0] exp_trig;
    int           exp_done;
    int           exp_shots;
    bit           exp_ovr;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_mask(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] bits4(input int a, input int b, input int c, input int d);
    logic [127:0] r;
    r = '0;
    if (a > 0) r[a] = 1'b1;
    if (b > 0) r[b] = 1'b1;
    if (c > 0) r[c] = 1'b1;
    if (d > 0) r[d] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input int period, input int count, input int mode, input bit cfg,
                              input int bfrom, input int bto, input logic [127:0] ext,
                              input int stop_at, input int wr_at, input int wr_val, input int ncyc,
                              input logic [127:0] etrig, input int edone, input int eshots,
                              input bit eovr);
    vec_t v;
    v.period = period;  v.count = count;   v.mode = mode;       v.cfg = cfg;
    v.busy_from = bfrom; v.busy_to = bto;  v.ext_mask = ext;    v.stop_at = stop_at;
    v.wr_at = wr_at;    v.wr_val = wr_val; v.ncyc = ncyc;       v.exp_trig = etrig;
    v.exp_done = edone; v.exp_shots = eshots; v.exp_ovr = eovr;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = 2'd0;
    bus.cfg_data    = 32'd0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.ext_trig    = 1'b0;
    bus.pulser_busy = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input int d);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = 32'(d);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Sets the inputs that the DUT will sample at edge k of the run.
  task automatic drive_for(input vec_t v, input int k);
    bus.pulser_busy = (k >= v.busy_from) && (k <= v.busy_to);
    bus.ext_trig    = v.ext_mask[k];
    bus.stop        = (k == v.stop_at);
    bus.cfg_we      = (k == v.wr_at);
    bus.cfg_addr    = ADDR_PERIOD;
    bus.cfg_data    = 32'(v.wr_val);
  endtask

  task automatic run_vec(input vec_t v, output logic [127:0] tmask, output int done_at,
                         output int ndone, output logic run1);
    tmask   = '0;
    done_at = -1;
    ndone   = 0;
    run1    = 1'b0;
    if (v.cfg) begin
      cfg_write(ADDR_PERIOD, v.period);
      cfg_write(ADDR_COUNT, v.count);
      cfg_write(ADDR_MODE, v.mode);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    drive_for(v, 1);
    for (int k = 1; k <= v.ncyc; k++) begin
      @(posedge clk);
      #1;
      if (bus.trig_out) tmask[k] = 1'b1;
      if (bus.done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) run1 = bus.running;
      drive_for(v, k + 1);
    end
    clear_inputs();
  endtask

  initial begin
    vec_t         vecs[13];
    logic [127:0] sat_mask;
    logic [127:0] tmask;
    int           done_at;
    int           ndone;
    logic         run1;
    int           seen;

    clear_inputs();
    sat_mask = '0;
    for (int k = 1; k <= 39; k += 2) sat_mask[k] = 1'b1;

    //           per cnt md cfg bfrom bto ext                 stop wr wv  ncyc exp_trig              done shots ovr
    vecs[0]  = mk(0,  0, 0, 0, 0, -1, '0,                   0,  0, 0, 105, bits4(1, -1, -1, -1),  101, 1,  0);
    vecs[1]  = mk(5,  4, 0, 1, 0, -1, '0,                   0,  0, 0, 25,  bits4(1, 6, 11, 16),   21,  4,  0);
    vecs[2]  = mk(5,  3, 0, 1, 5, 9,  '0,                   0,  0, 0, 25,  bits4(1, 11, 16, -1),  21,  3,  0);
    vecs[3]  = mk(5,  3, 2, 1, 5, 9,  '0,                   0,  0, 0, 25,  bits4(1, 11, 16, -1),  21,  3,  1);
    vecs[4]  = mk(10, 2, 1, 1, 0, -1, bits4(3, 6, 20, -1),  0,  0, 0, 35,  bits4(4, 21, -1, -1),  31,  2,  0);
    vecs[5]  = mk(4,  0, 0, 1, 0, -1, '0,                   9,  0, 0, 14,  bits4(1, 5, -1, -1),   10,  2,  0);
    vecs[6]  = mk(1,  3, 0, 1, 0, -1, '0,                   0,  0, 0, 10,  bits4(1, 3, 5, -1),    7,   3,  0);
    vecs[7]  = mk(0,  2, 0, 1, 0, -1, '0,                   0,  0, 0, 10,  bits4(1, 3, -1, -1),   5,   2,  0);
    vecs[8]  = mk(5,  3, 0, 1, 5, 30, '0,                   12, 0, 0, 16,  bits4(1, -1, -1, -1),  13,  1,  0);
    vecs[9]  = mk(6,  0, 1, 1, 0, -1, '0,                   5,  0, 0, 9,   '0,                    6,   0,  0);
    vecs[10] = mk(4,  0, 0, 1, 0, -1, '0,                   14, 3, 7, 18,  bits4(1, 5, 9, 13),    15,  4,  0);
    vecs[11] = mk(0,  0, 0, 0, 0, -1, '0,                   10, 0, 0, 14,  bits4(1, 8, -1, -1),   11,  2,  0);
    vecs[12] = mk(2,  0, 0, 1, 0, -1, '0,                   40, 0, 0, 44,  sat_mask,              41,  15, 0);

    repeat (3) @(negedge clk);
    check("rst_trig_out", bus.trig_out, 0);
    check("rst_running", bus.running, 0);
    check("rst_shot_count", bus.shot_count, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], tmask, done_at, ndone, run1);
      check_mask($sformatf("v%0d_trig_cycles", i), tmask, vecs[i].exp_trig);
      check($sformatf("v%0d_done_cycle", i), done_at, vecs[i].exp_done);
      check($sformatf("v%0d_done_pulses", i), ndone, 1);
      check($sformatf("v%0d_shot_count", i), bus.shot_count, vecs[i].exp_shots);
      check($sformatf("v%0d_overrun", i), bus.overrun, vecs[i].exp_ovr);
      check($sformatf("v%0d_running_c1", i), run1, 1);
      check($sformatf("v%0d_running_end", i), bus.running, 0);
      repeat (2) @(negedge clk);
    end

    // start and stop together while idle must not launch anything
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.trig_out || bus.running || bus.done) seen++;
    end
    check("idle_start_stop_activity", seen, 0);
    check("idle_start_stop_shots", bus.shot_count, 15);

    // asynchronous reset in the middle of a continuous train
    cfg_write(ADDR_PERIOD, 4);
    cfg_write(ADDR_COUNT, 0);
    cfg_write(ADDR_MODE, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_trig_out", bus.trig_out, 1);
    check("pre_rst_shot_count", bus.shot_count, 2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_trig_out", bus.trig_out, 0);
    check("mid_rst_running", bus.running, 0);
    check("mid_rst_shot_count", bus.shot_count, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.trig_out || bus.running || bus.done) seen++;
    end
    check("post_rst_idle_activity", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
